// File: rtl/multicycle_seq.sv
// Control sequencer for a multicycle processor: walks FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath enables for the current state and counts retired instructions.
module multicycle_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] inst1,
  input  logic       inst2,
  input  logic       mem_ready,
  input  logic       beq_taken,
  output logic [2:0] state,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       iorD,
  output logic [1:0] pcSrc,
  output logic [1:0] memToReg,
  output logic       done,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_JR  = 4'b1011;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1110;

  // Opcodes that take the normal EXEC path (everything legal except jr/jal).
  function automatic logic needs_exec(input logic [3:0] op);
    logic res;
    case (op)
      4'b0001, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000, 4'b1001,
      4'b1010, 4'b1100: res = 1'b1;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

  state_t     state_r;
  state_t     state_s;
  state_t     retire_to_s;
  logic [3:0] opcode_r;
  logic [3:0] dec_op_s;
  logic [7:0] retired_r;

  assign dec_op_s    = {inst1, inst2};
  assign retire_to_s = run ? S_FETCH : S_IDLE;
  assign state       = state_r;
  assign retired     = retired_r;

  // Next-state and datapath enables; enables follow mem_ready/beq_taken in the same cycle.
  always_comb begin
    state_s  = state_r;
    memRead  = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    iorD     = 1'b0;
    pcSrc    = 2'b00;
    memToReg = 2'b00;
    done     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        memRead = 1'b1;
        iorD    = 1'b0;
        if (mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          pcSrc   = 2'b00;
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Decode looks at the live instruction register; later states use opcode_r.
        case (dec_op_s)
          OP_JR: begin
            pcWrite = 1'b1;
            pcSrc   = 2'b11;
            done    = 1'b1;
            state_s = retire_to_s;
          end
          OP_JAL: begin
            pcWrite  = 1'b1;
            pcSrc    = 2'b10;
            regWrite = 1'b1;
            memToReg = 2'b10;
            done     = 1'b1;
            state_s  = retire_to_s;
          end
          default: begin
            if (needs_exec(dec_op_s)) begin
              state_s = S_EXEC;
            end else begin
              done    = 1'b1;
              state_s = retire_to_s;
            end
          end
        endcase
      end
      S_EXEC: begin
        if (opcode_r == OP_BEQ) begin
          pcWrite = beq_taken;
          pcSrc   = 2'b01;
          done    = 1'b1;
          state_s = retire_to_s;
        end else if ((opcode_r == OP_LW) || (opcode_r == OP_SW)) begin
          state_s = S_MEM;
        end else begin
          state_s = S_WB;
        end
      end
      S_MEM: begin
        iorD = 1'b1;
        if (opcode_r == OP_LW) begin
          memRead = 1'b1;
        end else begin
          memWrite = 1'b1;
        end
        if (!mem_ready) begin
          state_s = S_MEM;
        end else if (opcode_r == OP_LW) begin
          state_s = S_WB;
        end else begin
          done    = 1'b1;
          state_s = retire_to_s;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        if (opcode_r == OP_LW) begin
          memToReg = 2'b01;
        end else begin
          memToReg = 2'b00;
        end
        done    = 1'b1;
        state_s = retire_to_s;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, latched opcode and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      opcode_r  <= 4'd0;
      retired_r <= 8'd0;
    end else begin
      state_r <= state_s;
      if (state_r == S_DECODE) begin
        opcode_r <= dec_op_s;
      end
      if (done) begin
        retired_r <= retired_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: per-instruction expected cycle traces are
// built from the opcode rules, then replayed against the DUT cycle by cycle.
module tb_multicycle_seq;

  logic       clk = 1'b0;
  logic       rst, run, inst2, mem_ready, beq_taken;
  logic [2:0] inst1;
  logic [2:0] state;
  logic       memRead, memWrite, regWrite, irWrite, pcWrite, iorD, done;
  logic [1:0] pcSrc, memToReg;
  logic [7:0] retired;

  multicycle_seq dut (
    .clk(clk), .rst(rst), .run(run), .inst1(inst1), .inst2(inst2),
    .mem_ready(mem_ready), .beq_taken(beq_taken), .state(state),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .irWrite(irWrite), .pcWrite(pcWrite), .iorD(iorD), .pcSrc(pcSrc),
    .memToReg(memToReg), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic mrd, mwr, rw, irw, pcw, iord;
    logic [1:0] pcs, m2r;
    logic dn;
    logic [7:0] ret;
  } outs_t;

  typedef struct packed {
    logic r, ru, mr, bt;
    logic [3:0] ins;
    outs_t exp;
  } entry_t;

  entry_t q[$];
  logic [7:0] cnt = 8'd0;
  bit in_idle = 1'b1;
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [3:0] rins();
    return 4'($urandom_range(15, 0));
  endfunction

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110};
  endfunction

  task automatic push(input logic r, input logic ru, input logic m, input logic b,
                      input logic [3:0] i, input outs_t e);
    entry_t en;
    en.r = r; en.ru = ru; en.mr = m; en.bt = b; en.ins = i; en.exp = e;
    q.push_back(en);
  endtask

  // Retire cycle: done pulses, run decides FETCH vs IDLE, count advances afterwards.
  task automatic retire(input outs_t e, input logic [3:0] i, input logic b,
                        input logic m, input logic end_run);
    outs_t x;
    x = e;
    x.dn = 1'b1;
    push(1'b0, end_run, m, b, i, x);
    cnt = cnt + 8'd1;
    in_idle = !end_run;
  endtask

  task automatic push_idle(input int k);
    outs_t e;
    for (int i = 0; i < k; i++) begin
      e = '0; e.ret = cnt;
      push(1'b0, 1'b0, rb(), rb(), rins(), e);
    end
  endtask

  task automatic push_reset();
    outs_t e;
    e = '0; e.ret = cnt;
    push(1'b1, rb(), rb(), rb(), rins(), e);
    cnt = 8'd0;
    in_idle = 1'b1;
  endtask

  task automatic instr(input logic [3:0] op, input int fw, input int mw, input logic bt,
                       input logic end_run, input bit rst_mem);
    outs_t e;
    if (in_idle) begin
      e = '0; e.ret = cnt;
      push(1'b0, 1'b1, rb(), rb(), rins(), e);
    end
    for (int i = 0; i < fw; i++) begin
      e = '0; e.st = 3'd1; e.mrd = 1'b1; e.ret = cnt;
      push(1'b0, rb(), 1'b0, rb(), rins(), e);
    end
    e = '0; e.st = 3'd1; e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.ret = cnt;
    push(1'b0, rb(), 1'b1, rb(), rins(), e);
    e = '0; e.st = 3'd2; e.ret = cnt;
    if (op == 4'b1011) begin
      e.pcw = 1'b1; e.pcs = 2'b11;
      retire(e, op, rb(), rb(), end_run);
    end else if (op == 4'b1110) begin
      e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.m2r = 2'b10;
      retire(e, op, rb(), rb(), end_run);
    end else if (!legal(op)) begin
      retire(e, op, rb(), rb(), end_run);
    end else begin
      push(1'b0, rb(), rb(), rb(), op, e);
      e = '0; e.st = 3'd3; e.ret = cnt;
      if (op == 4'b1100) begin
        e.pcw = bt; e.pcs = 2'b01;
        retire(e, rins(), bt, rb(), end_run);
      end else begin
        push(1'b0, rb(), rb(), rb(), rins(), e);
        if (op == 4'b1000 || op == 4'b1001) begin
          e = '0; e.st = 3'd4; e.iord = 1'b1; e.ret = cnt;
          if (op == 4'b1000) e.mrd = 1'b1;
          else e.mwr = 1'b1;
          for (int i = 0; i < mw; i++) begin
            if (rst_mem) begin
              push(1'b1, 1'b1, 1'b0, rb(), rins(), e);
              cnt = 8'd0;
              in_idle = 1'b1;
              return;
            end
            push(1'b0, rb(), 1'b0, rb(), rins(), e);
          end
          if (op == 4'b1001) begin
            retire(e, rins(), rb(), 1'b1, end_run);
            return;
          end
          push(1'b0, rb(), 1'b1, rb(), rins(), e);
        end
        e = '0; e.st = 3'd5; e.rw = 1'b1; e.ret = cnt;
        e.m2r = (op == 4'b1000) ? 2'b01 : 2'b00;
        retire(e, rins(), rb(), rb(), end_run);
      end
    end
  endtask

  initial begin
    entry_t en;
    outs_t got;
    int n;
    logic er;
    rst = 1'b1; run = 1'b0; inst1 = 3'd0; inst2 = 1'b0; mem_ready = 1'b0; beq_taken = 1'b0;

    // Directed scenarios first, then random traffic, then the retire-counter wrap.
    push_reset();
    instr(4'b0001, 0, 0, 1'b0, 1'b1, 1'b0);
    instr(4'b1000, 2, 1, 1'b0, 1'b1, 1'b0);
    instr(4'b1100, 0, 0, 1'b1, 1'b1, 1'b0);
    instr(4'b1100, 0, 0, 1'b0, 1'b1, 1'b0);
    instr(4'b1110, 0, 0, 1'b0, 1'b1, 1'b0);
    instr(4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
    push_idle(3);
    instr(4'b1001, 0, 2, 1'b0, 1'b1, 1'b1);
    push_idle(2);
    instr(4'b1011, 1, 0, 1'b0, 1'b0, 1'b0);
    push_idle(3);
    for (int i = 0; i < 150; i++) begin
      er = (i == 149) ? 1'b0 : 1'($urandom_range(9, 0) != 0);
      instr(rins(), $urandom_range(3, 0), $urandom_range(3, 0), rb(), er, 1'b0);
      if (!er) push_idle($urandom_range(3, 1));
    end
    push_reset();
    for (int i = 0; i < 256; i++) begin
      instr(4'b1011, 0, 0, 1'b0, 1'(i != 255), 1'b0);
    end
    push_idle(2);

    @(posedge clk); #1;
    n = 0;
    while (q.size() > 0) begin
      en = q.pop_front();
      rst = en.r; run = en.ru; mem_ready = en.mr; beq_taken = en.bt;
      inst1 = en.ins[3:1]; inst2 = en.ins[0];
      @(negedge clk);
      got = {state, memRead, memWrite, regWrite, irWrite, pcWrite, iorD,
             pcSrc, memToReg, done, retired};
      check_eq($sformatf("cyc%0d_outs", n), 32'(got), 32'(en.exp));
      check_eq($sformatf("cyc%0d_rdwr_excl", n), 32'(memRead & memWrite), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
